mips_mem_responder: RTL and testbench
=====================================

// Module: mips_mem_responder
// PURPOSE
//   Single-port word memory responder serving load/store requests from the pipelined MIPS32 core.
//   Completes each request with valid/ready handshakes and a programmable number of wait states.
//   Includes a preload port so a bench or boot loader can write the program image before run.
//   Sits between the core's MEM-stage request interface and on-chip storage.
// PARAMETERS
//   ADDR_W       10    word-address width
//   DATA_W       32    data word width
//   DEPTH        1024  implemented words; must be <= 2**ADDR_W
//   WAIT_CYCLES  2     extra wait states per access (0..15)
// PORTS
//   clk        in   1       single clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   req_valid  in   1       request present
//   req_ready  out  1       responder can accept a request
//   req_we     in   1       1 = store, 0 = load
//   req_addr   in   ADDR_W  word address
//   req_wdata  in   DATA_W  store data
//   rsp_valid  out  1       response present
//   rsp_ready  in   1       requester takes the response
//   rsp_we     out  1       echo of req_we for this response
//   rsp_rdata  out  DATA_W  load data; 0 on stores and errors
//   rsp_err    out  1       address >= DEPTH
//   ld_en      in   1       preload write strobe
//   ld_addr    in   ADDR_W  preload address
//   ld_data    in   DATA_W  preload data
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - state IDLE; req_ready=0 while in reset; rsp_valid=0, rsp_we=0, rsp_rdata=0, rsp_err=0.
//     - Wait counter=0. Memory array is not reset.
//     - Deasserting rst_n mid-access drops the request; a pending store is never committed.
//   FSM states:
//     - IDLE: req_ready = !ld_en.
//       - If req_valid && req_ready: latch we/addr/wdata, cnt<=0, go to WAIT.
//       - If ld_en and ld_addr < DEPTH: mem[ld_addr] <= ld_data. Out-of-range preload is ignored.
//       - ld_en always wins over req_valid in the same cycle; the request is held off, not lost.
//     - WAIT: req_ready=0. Each cycle with cnt != WAIT_CYCLES: cnt <= cnt+1.
//       - When cnt == WAIT_CYCLES: perform the access and go to RESP with rsp_valid=1.
//       - Load in range: rsp_rdata <= mem[addr].
//       - Store in range: mem[addr] <= wdata, rsp_rdata <= 0.
//       - Any addr >= DEPTH: rsp_err=1, rsp_rdata=0, memory unchanged.
//     - RESP: req_ready=0. rsp_* held stable while rsp_valid && !rsp_ready.
//       - On rsp_ready: rsp_valid <= 0, rsp_err <= 0, go to IDLE.
//       - No back-to-back accept in the same cycle.
//   Latency and throughput:
//     - Accept at edge k; rsp_valid rises after edge k+WAIT_CYCLES+1.
//     - Minimum 1 idle cycle between responses: max throughput 1 per WAIT_CYCLES+3 cycles.
//   ld_en is ignored in WAIT and RESP (no effect on memory).
//   Address is word-granular; no byte enables; no wrap-around. Out-of-range addresses are flagged, not aliased.
// TESTING
//   1. Preload mem[5]=32'h1234_5678, then load addr 5 with WAIT_CYCLES=2
//      -> rsp_valid 3 cycles after accept; rsp_rdata=32'h1234_5678, rsp_err=0.
//   2. Store 32'hDEAD_BEEF to addr 10, then load addr 10
//      -> rsp_rdata=32'hDEAD_BEEF; store response has rsp_we=1, rsp_rdata=0.
//   3. Hold rsp_ready=0 for 5 cycles after rsp_valid
//      -> rsp_* stable and req_ready=0 throughout; completes on the first cycle rsp_ready=1.
//   4. DEPTH=1000, store to addr 1000
//      -> rsp_err=1; a following load of 1000 gives rsp_err=1, rdata=0; mem[0..999] unchanged.
//   5. ld_en=1 with req_valid=1 in IDLE
//      -> req_ready=0, preload written; request accepted the cycle after ld_en drops.
//   6. Assert rst_n=0 during WAIT of a store to addr 3 (mem[3]=7)
//      -> outputs at reset values immediately; after release mem[3] still 7 and state IDLE.

Source files
------------

// File: rtl/mips_mem_responder.sv
// rtl/mips_mem_responder.sv - word memory responder for the MIPS32 MEM stage
// Serves one load/store at a time with WAIT_CYCLES wait states and a preload port.
module mips_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      LP_WAIT  = 4'(WAIT_CYCLES);

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_rsp_valid;
  logic                r_rsp_we;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic w_req_ready;
  logic w_accept;
  logic w_access;
  logic w_rsp_done;
  logic w_in_range;
  logic w_ld_wr;

  assign w_in_range = ({1'b0, r_addr} < LP_DEPTH);
  // Gated by rst_n so reset keeps req_ready low and blocks any array write.
  assign w_ld_wr    = rst_n && (r_state == S_IDLE) && ld_en && ({1'b0, ld_addr} < LP_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = rst_n && !ld_en;
        if (req_valid && w_req_ready) begin
          w_accept = 1'b1;
          w_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == LP_WAIT) begin
          w_access = 1'b1;
          w_next   = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_done = 1'b1;
          w_next     = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= '0;
      end else if (r_state == S_WAIT && r_cnt != LP_WAIT) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_access) begin
        r_rsp_valid <= 1'b1;
        r_rsp_we    <= r_we;
        r_rsp_err   <= !w_in_range;
        r_rsp_rdata <= (!r_we && w_in_range) ? r_mem[r_addr] : '0;
      end else if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
        r_rsp_err   <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset; store and preload never overlap since they live in different states.
  always_ff @(posedge clk) begin
    if (w_access && r_we && w_in_range) r_mem[r_addr] <= r_wdata;
    else if (w_ld_wr)                   r_mem[ld_addr] <= ld_data;
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_we    = r_rsp_we;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mips_mem_responder.sv
// tb/tb_mips_mem_responder.sv - directed scoreboard bench for mips_mem_responder
module tb_mips_mem_responder;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1000;
  localparam int WC    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_we, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  typedef struct {
    logic          we;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [1024];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  mips_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    if (a < DEPTH) model[a] = d;
  endtask

  task automatic push_exp(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.we    = we;
    e.err   = (a >= DEPTH);
    e.rdata = (we || e.err) ? '0 : model[a];
    if (we && !e.err) model[a] = d;
    sb.push_back(e);
  endtask

  task automatic drive_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
  endtask

  task automatic wait_accept();
    int n = 0;
    #1;
    while (!req_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_bound", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    int            lat = 0;
    exp_t          e;
    logic [DW-1:0] s_rdata;
    logic          s_we, s_err;
    do begin
      @(posedge clk); #1; lat++;
    end while (!rsp_valid && lat < 20);
    chk("latency", 32'(lat), 32'(WC + 1));
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk("rsp_we", 32'(rsp_we), 32'(e.we));
      chk("rsp_rdata", rsp_rdata, e.rdata);
      chk("rsp_err", 32'(rsp_err), 32'(e.err));
    end
    s_rdata = rsp_rdata; s_we = rsp_we; s_err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_stable", {rsp_rdata[DW-3:0], s_we ^ rsp_we, s_err ^ rsp_err}, {s_rdata[DW-3:0], 2'b00});
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_clear", 32'(rsp_valid), 32'd0);
    chk("rsp_err_clear", 32'(rsp_err), 32'd0);
  endtask

  task automatic access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
    push_exp(we, a, d);
    drive_req(we, a, d);
    wait_accept();
    collect(hold);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp", {rsp_rdata[DW-4:0], rsp_valid, rsp_we, rsp_err}, '0);
    @(negedge clk); rst_n = 1'b1;

    // Preload and load back with the nominal wait-state latency.
    preload(10'd5, 32'h1234_5678);
    access(1'b0, 10'd5, '0, 0);

    // Store followed by a load of the same word.
    access(1'b1, 10'd10, 32'hDEAD_BEEF, 0);
    access(1'b0, 10'd10, '0, 0);

    // Response backpressure for five cycles.
    access(1'b0, 10'd5, '0, 5);

    // Out-of-range addresses are flagged and never alias into the array.
    preload(10'd0, 32'hA5A5_0000);
    preload(10'd999, 32'h0000_5A5A);
    preload(10'd1000, 32'hFFFF_FFFF);
    access(1'b1, 10'd1000, 32'hCAFE_F00D, 0);
    access(1'b0, 10'd1000, '0, 0);
    access(1'b0, 10'd999, '0, 0);
    access(1'b0, 10'd0, '0, 0);

    // Preload has priority over a simultaneous request, which is held off.
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 10'd20; ld_data = 32'h0BAD_C0DE;
    model[20] = 32'h0BAD_C0DE;
    push_exp(1'b0, 10'd20, '0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd20; req_wdata = '0;
    #1;
    chk("ld_blocks_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("ld_no_accept", 32'(req_ready), 32'd0);
    @(negedge clk);
    ld_en = 1'b0;
    #1;
    chk("ready_after_ld", 32'(req_ready), 32'd1);
    wait_accept();
    collect(0);

    // Reset during the wait phase of a store drops it.
    preload(10'd3, 32'd7);
    drive_req(1'b1, 10'd3, 32'h1111_2222);
    wait_accept();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_req_ready", 32'(req_ready), 32'd0);
    chk("midreset_rsp", {rsp_rdata[DW-4:0], rsp_valid, rsp_we, rsp_err}, '0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("idle_after_reset", 32'(req_ready), 32'd1);
    access(1'b0, 10'd3, '0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
